// File: rtl/updn_counter_pkg.sv
// Shared constants and next-count helper for the up/down counter.
// Used by the RTL and by the testbench scoreboard so both agree on wrap rules.
package updn_counter_pkg;

    localparam int unsigned UPDN_DEFAULT_WIDTH = 4;
    localparam logic        UPDN_DIR_UP        = 1'b1;
    localparam logic        UPDN_DIR_DOWN      = 1'b0;

    // All-ones mask of the given width (1..32); built in 33 bits so width=32 is safe.
    function automatic logic [31:0] updn_mask(input int unsigned width);
        logic [32:0] m;
        m = (33'd1 << width) - 33'd1;
        return m[31:0];
    endfunction

    // Modulo-2^width next count: +1 when counting up, -1 when counting down.
    function automatic logic [31:0] updn_next(input logic [31:0] q,
                                              input logic ud,
                                              input int unsigned width = UPDN_DEFAULT_WIDTH);
        logic [31:0] n;
        n = (ud == UPDN_DIR_UP) ? (q + 32'd1) : (q - 32'd1);
        return n & updn_mask(width);
    endfunction

endpackage

// File: rtl/updn_counter_if.sv
// Bundle of the counter's direction/count signals for harness-side wiring.
// The counter itself keeps flat positional ports so legacy instantiations bind;
// this interface groups the same signals for whoever drives/observes them.
interface updn_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             ud;
    logic [WIDTH-1:0] q;
    logic             tc;

    // Driver side: chooses direction, observes count and terminal flag.
    modport master (output ud, input q, input tc);
    // Counter side: consumes direction, produces count and terminal flag.
    modport slave  (input ud, output q, output tc);
endinterface

// File: rtl/updn_counter.sv
// Parameterised modulo-2^WIDTH up/down counter, one register, no hold state.
// Optional build macro UPDN_COUNTER_TC_EN adds a registered terminal-count
// output TC, appended after Q in the port list.
module updn_counter
    import updn_counter_pkg::*;
#(
    parameter int unsigned WIDTH = UPDN_DEFAULT_WIDTH
) (
    input  logic             RESETN,
    input  logic             CLK,
    input  logic             UD,
    output logic [WIDTH-1:0] Q
`ifdef UPDN_COUNTER_TC_EN
    ,
    output logic             TC
`endif
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: a single adder/subtractor selected by UD, wrapping both ways.
    always_comb begin
        q_d = WIDTH'(updn_next(32'(q_q), UD, WIDTH));
    end

    // Count register; RESETN clears it immediately, regardless of CLK.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) q_q <= '0;
        else         q_q <= q_d;
    end

    assign Q = q_q;

`ifdef UPDN_COUNTER_TC_EN
    localparam logic [WIDTH-1:0] ONES = '1;

    logic tc_q;
    logic tc_d;

    // Terminal flag tracks the value being loaded: all-ones going up, zero going down.
    always_comb begin
        tc_d = (q_d == ((UD == UPDN_DIR_UP) ? ONES : '0));
    end

    // Flag register sits beside the count so both change on the same edge.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) tc_q <= 1'b0;
        else         tc_q <= tc_d;
    end

    assign TC = tc_q;
`endif

endmodule

// File: tb/tb_updn_counter.sv
// Directed check of updn_counter at WIDTH=4 (hand-computed table) with WIDTH=1
// and WIDTH=8 instances run alongside against a scoreboard.
// Build with +define+UPDN_COUNTER_TC_EN to also check TC.
module tb_updn_counter;
    import updn_counter_pkg::*;

    logic clk;
    logic rst_n;

    updn_counter_if #(.WIDTH(4)) bus4 ();
    updn_counter_if #(.WIDTH(1)) bus1 ();
    updn_counter_if #(.WIDTH(8)) bus8 ();

    updn_counter #(.WIDTH(4)) dut4 (
        .RESETN(rst_n), .CLK(clk), .UD(bus4.ud), .Q(bus4.q)
`ifdef UPDN_COUNTER_TC_EN
        , .TC(bus4.tc)
`endif
    );
    updn_counter #(.WIDTH(1)) dut1 (
        .RESETN(rst_n), .CLK(clk), .UD(bus1.ud), .Q(bus1.q)
`ifdef UPDN_COUNTER_TC_EN
        , .TC(bus1.tc)
`endif
    );
    updn_counter #(.WIDTH(8)) dut8 (
        .RESETN(rst_n), .CLK(clk), .UD(bus8.ud), .Q(bus8.q)
`ifdef UPDN_COUNTER_TC_EN
        , .TC(bus8.tc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       pulse;   // drop RESETN between edges before this vector
        logic       rstn;    // RESETN level for this edge
        logic       ud;
        logic [3:0] exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] m1, m4, m8;
    logic        mt1, mt4, mt8;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic p, input logic r, input logic u,
                                input int q, input logic tc);
        vec_t v;
        v.pulse  = p;
        v.rstn   = r;
        v.ud     = u;
        v.exp_q  = 4'(q);
        v.exp_tc = tc;
        vt.push_back(v);
    endfunction

    task automatic set_ud(input logic u);
        bus1.ud = u;
        bus4.ud = u;
        bus8.ud = u;
    endtask

    function automatic logic tc_of(input logic [31:0] n, input logic u, input int unsigned w);
        return n == ((u == UPDN_DIR_UP) ? updn_mask(w) : 32'd0);
    endfunction

    // One rising edge, then advance the scoreboard; checks the WIDTH=1/8 instances.
    task automatic tick(input bit chk4);
        @(posedge clk);
        #1;
        if (rst_n) begin
            m1 = updn_next(m1, bus4.ud, 1);
            m4 = updn_next(m4, bus4.ud, 4);
            m8 = updn_next(m8, bus4.ud, 8);
            mt1 = tc_of(m1, bus4.ud, 1);
            mt4 = tc_of(m4, bus4.ud, 4);
            mt8 = tc_of(m8, bus4.ud, 8);
        end else begin
            m1 = '0; m4 = '0; m8 = '0;
            mt1 = 1'b0; mt4 = 1'b0; mt8 = 1'b0;
        end
        chk("q_w1", 32'(bus1.q), m1);
        chk("q_w8", 32'(bus8.q), m8);
        if (chk4) chk("q_w4_sb", 32'(bus4.q), m4);
`ifdef UPDN_COUNTER_TC_EN
        chk("tc_w1", 32'(bus1.tc), 32'(mt1));
        chk("tc_w8", 32'(bus8.tc), 32'(mt8));
        if (chk4) chk("tc_w4_sb", 32'(bus4.tc), 32'(mt4));
`endif
    endtask

    task automatic async_zero_check(input string nm);
        chk({nm, "_w4"}, 32'(bus4.q), 32'd0);
        chk({nm, "_w1"}, 32'(bus1.q), 32'd0);
        chk({nm, "_w8"}, 32'(bus8.q), 32'd0);
`ifdef UPDN_COUNTER_TC_EN
        chk({nm, "_tc"}, 32'(bus4.tc), 32'd0);
`endif
    endtask

    initial begin
        m1 = '0; m4 = '0; m8 = '0;
        mt1 = 1'b0; mt4 = 1'b0; mt8 = 1'b0;
        rst_n = 1'b0;
        set_ud(1'b1);

        // Up 1..3 out of reset.
        add(0, 1, 1, 1, 0); add(0, 1, 1, 2, 0); add(0, 1, 1, 3, 0);
        // Async clear at Q=3, then three edges with reset held low.
        add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0);
        // Release counting down: wrap to 15 then down to 0; TC only entering 0.
        for (int i = 15; i >= 0; i--) add(0, 1, 0, i, i == 0);
        // Up 1..15 then wrap to 0; TC only entering 15.
        for (int i = 1; i <= 16; i++) add(0, 1, 1, i % 16, i == 15);
        // Direction reversal: up to 5, down 4,3, up 4.
        for (int i = 1; i <= 5; i++) add(0, 1, 1, i, 0);
        add(0, 1, 0, 4, 0); add(0, 1, 0, 3, 0); add(0, 1, 1, 4, 0);
        // Up to 9, then async pulse and restart up from 0.
        for (int i = 5; i <= 9; i++) add(0, 1, 1, i, 0);
        add(1, 1, 1, 1, 0);

        // Reset state before any edge.
        #2;
        async_zero_check("reset");
        rst_n = 1'b1;

        foreach (vt[k]) begin
            if (vt[k].pulse) begin
                rst_n = 1'b0;
                #1;
                m1 = '0; m4 = '0; m8 = '0;
                async_zero_check($sformatf("async_%0d", k));
                #1;
                rst_n = vt[k].rstn;
                #1;
                async_zero_check($sformatf("post_rel_%0d", k));
            end
            rst_n = vt[k].rstn;
            set_ud(vt[k].ud);
            tick(1'b0);
            chk($sformatf("q_w4_v%0d", k), 32'(bus4.q), 32'(vt[k].exp_q));
`ifdef UPDN_COUNTER_TC_EN
            chk($sformatf("tc_w4_v%0d", k), 32'(bus4.tc), 32'(vt[k].exp_tc));
`endif
        end

        // Sweep: 2^8+1 edges each direction covers every wrap for all widths.
        set_ud(UPDN_DIR_UP);
        for (int i = 0; i < 257; i++) tick(1'b1);
        set_ud(UPDN_DIR_DOWN);
        for (int i = 0; i < 257; i++) tick(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
